fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that owns the program counter and drives the byte address into the instruction memory (instMem).
- Captures the returned 32-bit word into an IF/ID pipeline register for the decode stage.
- Handles sequential increment, stall, branch/jump redirect with flush, and a halt-word stop condition.
- instMem is combinational: address this cycle, data this cycle, captured at the next rising edge.

Parameters:
- PC_W, 15, PC and instruction-memory byte-address width; must match instMem's pc port.
- RESET_PC, 15'h0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- NOP_WORD, 32'h0000_0000, encoding placed in IF/ID on bubble or flush.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- redirect_valid  input  1  branch taken or jump resolved this cycle.
- redirect_target  input  PC_W  new PC for a redirect.
- pc  output  PC_W  current fetch address, driven straight from the PC register to instMem pc.
- ins_data  input  32  instruction word from instMem insData for address pc.
- if_id_instr  output  32  registered instruction for decode.
- if_id_pc4  output  PC_W  registered address of the captured instruction plus 4.
- if_id_valid  output  1  if_id_instr holds a real instruction.
- halted  output  1  a halt word has been captured; fetch frozen.
- misalign_err  output  1  sticky; a redirect target had nonzero bits [1:0].
- fetch_count  output  CNT_W  number of valid instructions captured.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0.
  - halted=0, misalign_err=0, fetch_count=0.
  - Deassertion takes effect at the next edge; the first capture is the word at RESET_PC.
- Arithmetic:
  - pc+4 is modulo 2^PC_W, so 32764+4 wraps to 0 with no flag.
  - The redirect target is forced word-aligned: bits [1:0] are cleared before loading.
  - If the raw target had nonzero bits [1:0], misalign_err sets and stays set until reset.
- Per-edge priority (highest first):
  1. redirect_valid=1: pc<=aligned target, IF/ID<=bubble (instr=NOP_WORD, valid=0), halted<=0. Overrides stall and halted because the word in IF is wrong-path.
  2. halted=1: pc holds, IF/ID<=bubble.
  3. stall=1: pc, if_id_instr, if_id_pc4 and if_id_valid all hold; fetch_count holds.
  4. Otherwise:
     - if_id_instr<=ins_data, if_id_pc4<=pc+4, if_id_valid<=1, fetch_count increments.
     - If ins_data==HALT_WORD: pc holds and halted<=1. The halt word itself is passed to decode as valid.
     - Else pc<=pc+4.
- fetch_count saturates at all-ones; it counts only valid captures, not bubbles or stalled cycles.
- Latency: an address presented on pc appears on if_id_instr one edge later. A redirect adds one bubble cycle.
- Reset mid-operation: all state clears immediately regardless of stall, redirect or halted.
- stall and redirect together: the redirect wins and stall is ignored that cycle.

Test Plan:
- Sequential fetch: memory words 0..3 = A,B,C,D; release reset -> pc 0,4,8,12 on successive cycles; if_id_instr A,B,C with pc4 4,8,12; valid=1 from the first edge after reset; fetch_count=3 after 3 edges.
- Stall: assert stall for 2 cycles at pc=8 -> pc stays 8, IF/ID holds B/pc4=8, count unchanged; release -> captures C, pc=12.
- Redirect with a simultaneous stall:
  - redirect_target=0x0042 plus stall=1 at pc=12 -> next edge pc=0x0040, valid=0, instr=0, misalign_err=1.
  - Following edge captures the word at 0x40 with pc4=0x44.
- Halt:
  - HALT_WORD at address 16 -> captured with valid=1, halted=1, pc frozen at 16, subsequent valid=0.
  - Then redirect to 0x20 -> halted=0, fetch resumes at 0x20.
- Wrap: redirect to 32764 -> next cycle pc=0; if_id_pc4=0 for the word at 32764.
- Async reset mid-stream: pull rst_n low between edges while valid=1 and count=5 -> outputs clear immediately to the reset values without a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a combinational instMem and
// registers the returned word into the IF/ID pipeline register.
module fetch_stage #(
    parameter int              PC_W      = 15,
    parameter logic [PC_W-1:0] RESET_PC  = 15'h0000,
    parameter logic [31:0]     HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0]     NOP_WORD  = 32'h0000_0000,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_target,
    output logic [PC_W-1:0]  pc,
    input  logic [31:0]      ins_data,
    output logic [31:0]      if_id_instr,
    output logic [PC_W-1:0]  if_id_pc4,
    output logic             if_id_valid,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_instr;
    logic [PC_W-1:0]  r_pc4;
    logic             r_valid;
    logic             r_halted;
    logic             r_misalign;
    logic [CNT_W-1:0] r_count;

    logic [PC_W-1:0]  w_pc_plus4;
    logic [PC_W-1:0]  w_target_aligned;
    logic             w_target_misaligned;
    logic             w_is_halt;
    logic [CNT_W-1:0] w_count_next;

    // pc+4 wraps silently at 2^PC_W.
    assign w_pc_plus4          = r_pc + PC_W'(4);
    assign w_target_aligned    = {redirect_target[PC_W-1:2], 2'b00};
    assign w_target_misaligned = |redirect_target[1:0];
    assign w_is_halt           = (ins_data == HALT_WORD);
    assign w_count_next        = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset clears all state asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_WORD;
            r_pc4      <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            // The word currently in IF is wrong-path: squash it even if stalled or halted.
            r_pc     <= w_target_aligned;
            r_instr  <= NOP_WORD;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            if (w_target_misaligned) begin
                r_misalign <= 1'b1;
            end
        end else if (r_halted) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_instr <= ins_data;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
            r_count <= w_count_next;
            if (w_is_halt) begin
                r_halted <= 1'b1;
            end else begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    assign pc           = r_pc;
    assign if_id_instr  = r_instr;
    assign if_id_pc4    = r_pc4;
    assign if_id_valid  = r_valid;
    assign halted       = r_halted;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a combinational word-addressed memory model
// feeds ins_data, and each step compares the outputs to hand-derived values.
module tb_fetch_stage;

    localparam int PC_W  = 15;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_target;
    logic [PC_W-1:0]  pc;
    logic [31:0]      ins_data;
    logic [31:0]      if_id_instr;
    logic [PC_W-1:0]  if_id_pc4;
    logic             if_id_valid;
    logic             halted;
    logic             misalign_err;
    logic [CNT_W-1:0] fetch_count;

    logic [31:0] mem [0:8191];
    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .ins_data        (ins_data),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    assign ins_data = mem[pc[PC_W-1:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic e_halted,
                             input logic [31:0] e_count);
        chk({tag, ".pc"},    32'(pc),          e_pc);
        chk({tag, ".instr"}, if_id_instr,      e_instr);
        chk({tag, ".pc4"},   32'(if_id_pc4),   e_pc4);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
        chk({tag, ".halt"},  32'(halted),      32'(e_halted));
        chk({tag, ".count"}, 32'(fetch_count), e_count);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[4] = 32'hFFFF_FFFF;

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        #12;
        chk_state("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.mis", 32'(misalign_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_state("released", 0, 0, 0, 0, 0, 0);

        // Sequential fetch.
        step(); chk_state("seq1", 4, 32'hA000_0000, 4, 1, 0, 1);
        step(); chk_state("seq2", 8, 32'hA000_0001, 8, 1, 0, 2);

        // Two-cycle stall at pc=8.
        stall = 1'b1;
        step(); chk_state("stall1", 8, 32'hA000_0001, 8, 1, 0, 2);
        step(); chk_state("stall2", 8, 32'hA000_0001, 8, 1, 0, 2);
        stall = 1'b0;
        step(); chk_state("unstall", 12, 32'hA000_0002, 12, 1, 0, 3);

        // Misaligned redirect with simultaneous stall: redirect wins.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 15'h0042;
        step(); chk_state("redir", 32'h40, 0, 12, 0, 0, 3);
        chk("redir.mis", 32'(misalign_err), 1);
        stall = 1'b0; redirect_valid = 1'b0;
        step(); chk_state("redir_cap", 32'h44, 32'hA000_0010, 32'h44, 1, 0, 4);

        // Halt word at address 16.
        redirect_valid = 1'b1; redirect_target = 15'h0010;
        step(); chk_state("to_halt", 32'h10, 0, 32'h44, 0, 0, 4);
        redirect_valid = 1'b0;
        step(); chk_state("halt_cap", 32'h10, 32'hFFFF_FFFF, 32'h14, 1, 1, 5);
        step(); chk_state("halted", 32'h10, 0, 32'h14, 0, 1, 5);
        step(); chk_state("halted2", 32'h10, 0, 32'h14, 0, 1, 5);
        redirect_valid = 1'b1; redirect_target = 15'h0020;
        step(); chk_state("unhalt", 32'h20, 0, 32'h14, 0, 0, 5);
        redirect_valid = 1'b0;
        step(); chk_state("resume", 32'h24, 32'hA000_0008, 32'h24, 1, 0, 6);
        chk("resume.mis", 32'(misalign_err), 1);

        // Wrap from 32764 to 0.
        redirect_valid = 1'b1; redirect_target = 15'h7FFC;
        step(); chk_state("to_wrap", 32'h7FFC, 0, 32'h24, 0, 0, 6);
        redirect_valid = 1'b0;
        step(); chk_state("wrap", 0, 32'hA000_1FFF, 0, 1, 0, 7);
        step(); chk_state("post_wrap", 4, 32'hA000_0000, 4, 1, 0, 8);

        // Fresh run to valid=1, count=5, then asynchronous reset between edges.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_state("reset2", 0, 0, 0, 0, 0, 0);
        chk("reset2.mis", 32'(misalign_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk_state("run5", 32'h10, 32'hFFFF_FFFF, 32'h14, 1, 1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 0, 0, 0, 0);
        step(); chk_state("held_rst", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
